mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle datapath's memory port.
- Accepts one word, halfword or byte read/write request at a time from the CPU initiator and models a wait-stated synchronous RAM.
- Sub-word stores use an internal read-modify-write; sub-word loads return a zero-extended result.
- Misaligned or out-of-range accesses are signalled as a fault response.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the storage array (power of two, ≥4).
- LATENCY, 2, wait cycles inserted before the array access (0..15).

Ports:
- Clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- wr  in  1  1 = write, 0 = read; sampled with req.
- size  in  2  00 word, 01 byte, 10 halfword, 11 reserved (treated as fault).
- addr  in  32  byte address; sampled with req.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]); sampled with req.
- ready  out  1  one-cycle response strobe.
- rdata  out  32  load result; valid when ready=1 and wr=0; held until next response.
- fault  out  1  valid with ready; 1 = misaligned/out-of-range/reserved size.
- busy  out  1  high from the accepting edge until the cycle ready is asserted, inclusive.

Behaviour:
- Reset (reset=0, async): state IDLE; ready=0, fault=0, busy=0, rdata=0, counter=0. Storage array is NOT cleared. Reset mid-operation abandons the request with no array write.
- States: IDLE, WAIT, ACCESS, MERGE, RESP.
- IDLE: req=1 latches wr/size/addr/wdata, loads counter=LATENCY and enters WAIT (or ACCESS directly if LATENCY=0).
- WAIT: decrement counter; enter ACCESS when counter reaches 1.
- ACCESS:
  - Fault check first: word with addr[1:0]≠0, half with addr[0]=1, size=11, or addr[31:2] ≥ DEPTH_WORDS → RESP with fault=1, no write, rdata unchanged.
  - Read: rdata = extract(word, size, addr[1:0]) → RESP.
  - Word write: array[addr[31:2]] = wdata → RESP.
  - Sub-word write: latch old word → MERGE.
- MERGE: array[idx] = merge(old, wdata, size, addr[1:0]) → RESP.
- RESP: ready=1 and fault valid for exactly one cycle → IDLE.
- Lanes are little-endian:
  - byte k occupies bits [8k+7:8k];
  - half at addr[1]=1 occupies [31:16].
  - Loads are zero-extended to 32 bits.
- Timing, from request accepted at edge E0:
  - ready is high in the cycle after edge E0+LATENCY+1 for reads, word writes and faults;
  - one cycle later for sub-word writes.
  - With LATENCY=2, a read has ready high 3 cycles after acceptance.
- req while busy is ignored; no queuing. Deasserting req mid-operation does not abort.
- A req asserted in the RESP cycle is not accepted; it is accepted in the following IDLE cycle if still high.
- Array read is synchronous and array write happens at the edge leaving ACCESS/MERGE. A read issued immediately after a write to the same word returns the new data.

Optional Feature:
- Macro MEM_RESP_ERRCNT_EN.
- When defined: adds output err_count (8 bits), reset to 0, incremented on every fault response, saturating at 255.
- When undefined: port and counter are absent; fault behaviour is otherwise identical.

Decomposition:
- Package mem_resp_pkg holds:
  - enum mem_size_t (SZ_WORD=2'b00, SZ_BYTE=2'b01, SZ_HALF=2'b10);
  - enum mem_resp_state_t (IDLE, WAIT, ACCESS, MERGE, RESP);
  - constant WORD_BYTES=4.
- One combinational sub-module, mem_lane_merge: inputs old word, wdata, size, addr[1:0]; outputs merged word and extracted zero-extended load value. Used by both the ACCESS and MERGE paths.

Test Plan:
- LATENCY=2, word write addr=0x10 wdata=0xDEADBEEF, then word read 0x10 → ready 3 cycles after each acceptance; rdata=0xDEADBEEF, fault=0.
- After the above, byte write addr=0x11 wdata=0x000000AA, then word read 0x10 → rdata=0xDEADAAEF; byte write ready arrives one cycle later than the word write.
- Half read addr=0x12 → rdata=0x0000DEAD; byte read addr=0x13 → rdata=0x000000DE.
- Word read addr=0x02; half write addr=0x05; word read addr=DEPTH_WORDS*4 → each gives fault=1 with ready; array unchanged (re-read 0x04 returns prior value); err_count=3 when MEM_RESP_ERRCNT_EN is defined.
- Second req pulsed while busy → ignored; exactly one ready pulse; busy deasserts after ready.
- Assert reset=0 during WAIT of a word write 0x20=0x12345678 → ready stays 0, busy=0 immediately; subsequent read of 0x20 returns the pre-existing value.

Source files
------------

// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_pkg
// Purpose  : Shared types and constants for the memory responder: access
//            size encoding, responder state encoding, bytes per word.
// Revision : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

  // Access size as driven on the bus; 2'b11 is reserved and faults.
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10
  } mem_size_t;

  // Responder sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    ACCESS = 3'd2,
    MERGE  = 3'd3,
    RESP   = 3'd4
  } mem_resp_state_t;

  localparam int WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_if
// Purpose  : Request/response bundle between the CPU memory initiator
//            (master) and the memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        fault;
  logic        busy;

  modport master (
    output req, wr, size, addr, wdata,
    input  ready, rdata, fault, busy
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output ready, rdata, fault, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_lane_merge.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_merge
// Purpose  : Little-endian lane steering. Produces the store word with the
//            addressed byte/half replaced by wdata, and the zero-extended
//            load value extracted from the addressed lane.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_merge
  import mem_resp_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  byte_off,
  output logic [31:0] merged,
  output logic [31:0] load
);

  // Lane select for both the store merge and the load extract.
  always_comb begin
    merged = old_word;
    load   = '0;
    case (size)
      SZ_WORD: begin
        merged = wdata;
        load   = old_word;
      end
      SZ_BYTE: begin
        merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
        load = {24'd0, old_word[{byte_off, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        // Only addr[1] picks the half; addr[0]=1 is caught as a fault.
        if (byte_off[1]) begin
          merged[31:16] = wdata[15:0];
          load          = {16'd0, old_word[31:16]};
        end else begin
          merged[15:0]  = wdata[15:0];
          load          = {16'd0, old_word[15:0]};
        end
      end
      default: begin
        merged = old_word;
        load   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Wait-stated single-outstanding memory responder. Word, half and
//            byte accesses; sub-word stores via read-modify-write; misaligned,
//            out-of-range and reserved-size accesses return a fault.
//            Optional macro MEM_RESP_ERRCNT_EN adds a saturating 8-bit
//            fault counter output err_count.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             Clk,
  input  logic             reset,
  mem_responder_if.slave   bus
`ifdef MEM_RESP_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_WAIT   = WAIT;
  localparam logic [2:0] ST_ACCESS = ACCESS;
  localparam logic [2:0] ST_MERGE  = MERGE;
  localparam logic [2:0] ST_RESP   = RESP;

  localparam logic [3:0] LAT_INIT  = 4'(LATENCY);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_old;
  logic        r_fault;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_arr_word;
  logic [31:0]      w_old_sel;
  logic [31:0]      w_merged;
  logic [31:0]      w_load;
  logic             w_range_fault;
  logic             w_align_fault;
  logic             w_fault;
  logic             w_we;

  assign w_idx      = r_addr[IDX_W+OFF_W-1:OFF_W];
  assign w_arr_word = r_mem[w_idx];

  // DEPTH_WORDS is a power of two, so any set bit above the index is out of range.
  assign w_range_fault = |r_addr[31:IDX_W+OFF_W];
  assign w_align_fault = ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00)) ||
                         ((r_size == SZ_HALF) && r_addr[0]) ||
                         (r_size == 2'b11);
  assign w_fault = w_range_fault | w_align_fault;

  // MERGE works from the word captured in ACCESS; ACCESS reads the array directly.
  assign w_old_sel = (r_state == ST_MERGE) ? r_old : w_arr_word;

  mem_lane_merge u_lane_merge (
    .old_word (w_old_sel),
    .wdata    (r_wdata),
    .size     (r_size),
    .byte_off (r_addr[1:0]),
    .merged   (w_merged),
    .load     (w_load)
  );

  // For word stores the merged word is simply wdata, so one write port serves both paths.
  assign w_we = reset &&
                (((r_state == ST_ACCESS) && !w_fault && r_wr && (r_size == SZ_WORD)) ||
                 (r_state == ST_MERGE));

  // Storage array: synchronous write, never cleared by reset.
  always_ff @(posedge Clk) begin
    if (w_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Request sequencing: latch, wait-state, access, optional merge, respond.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_old   <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_wr    <= bus.wr;
            r_size  <= bus.size;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_cnt   <= LAT_INIT;
            r_fault <= 1'b0;
            r_state <= (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_fault) begin
            r_fault <= 1'b1;
            r_state <= ST_RESP;
          end else if (!r_wr) begin
            r_rdata <= w_load;
            r_state <= ST_RESP;
          end else if (r_size == SZ_WORD) begin
            r_state <= ST_RESP;
          end else begin
            r_old   <= w_arr_word;
            r_state <= ST_MERGE;
          end
        end
        ST_MERGE: begin
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (r_state == ST_RESP);
  assign bus.fault = (r_state == ST_RESP) && r_fault;
  assign bus.busy  = (r_state != ST_IDLE);
  assign bus.rdata = r_rdata;

`ifdef MEM_RESP_ERRCNT_EN
  logic [7:0] r_err_count;

  // Saturating count of fault responses, bumped as the fault is decided.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else if ((r_state == ST_ACCESS) && w_fault && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Scoreboard bench for mem_responder (DEPTH_WORDS=256,
//            LATENCY=2). Directed requests push expected responses; a monitor
//            checks each ready pulse for data, fault and arrival cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  always #5 Clk = ~Clk;

  mem_responder_if bus ();
`ifdef MEM_RESP_ERRCNT_EN
  logic [7:0] err_count;
`endif

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_RESP_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        chk;
    logic        fault;
    int          rcyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_ready = 0;
  int    cyc = 0;
  logic [31:0] last_rdata = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    exp_t  e;
    string nm;
    if (bus.ready === 1'b1) begin
      n_ready++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got ready at cycle %0d, wanted none", cyc);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_fault"}, {31'd0, bus.fault}, {31'd0, e.fault});
        check({nm, "_cycle"}, cyc, e.rcyc);
        if (e.chk) check({nm, "_rdata"}, bus.rdata, e.rdata);
      end
    end
  end

  task automatic wait_done(input string nm);
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < 60) begin
      @(negedge Clk);
      k++;
    end
    if (k >= 60) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no response in 60 cycles, wanted one", nm);
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.req   = 1'b1;
    bus.wr    = w;
    bus.size  = sz;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  // Push the expectation for a request accepted on the edge just passed.
  task automatic expect_resp(input logic w, input logic [31:0] er, input logic ef,
                             input int extra, input string nm);
    exp_t e;
    e.fault = ef;
    e.rcyc  = cyc + LAT + 1 + extra;
    if (ef) begin
      e.rdata = last_rdata;
      e.chk   = 1'b1;
    end else if (!w) begin
      e.rdata    = er;
      e.chk      = 1'b1;
      last_rdata = er;
    end else begin
      e.rdata = '0;
      e.chk   = 1'b0;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One complete transaction. extra=1 for sub-word stores (merge cycle).
  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ef,
                       input int extra, input string nm);
    @(negedge Clk);
    drive(w, sz, a, d);
    @(posedge Clk);
    #1;
    expect_resp(w, er, ef, extra, nm);
    bus.req = 1'b0;
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, wanted finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.addr = '0; bus.wdata = '0;

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    reset = 1'b1;

    // Background contents
    issue(1'b1, SZ_WORD, 32'h04,  32'h11223344, '0, 1'b0, 0, "init_w04");
    issue(1'b1, SZ_WORD, 32'h20,  32'hCAFEF00D, '0, 1'b0, 0, "init_w20");
    issue(1'b1, SZ_WORD, 32'h3FC, 32'h01020304, '0, 1'b0, 0, "init_w3fc");

    // Word write/read, then byte RMW
    issue(1'b1, SZ_WORD, 32'h10, 32'hDEADBEEF, '0, 1'b0, 0, "w10");
    issue(1'b0, SZ_WORD, 32'h10, '0, 32'hDEADBEEF, 1'b0, 0, "r10");
    issue(1'b1, SZ_BYTE, 32'h11, 32'h000000AA, '0, 1'b0, 1, "bw11");
    issue(1'b0, SZ_WORD, 32'h10, '0, 32'hDEADAAEF, 1'b0, 0, "r10_after_bw");

    // Sub-word loads, zero-extended
    issue(1'b0, SZ_HALF, 32'h12, '0, 32'h0000DEAD, 1'b0, 0, "hr12");
    issue(1'b0, SZ_BYTE, 32'h13, '0, 32'h000000DE, 1'b0, 0, "br13");
    issue(1'b0, SZ_BYTE, 32'h11, '0, 32'h000000AA, 1'b0, 0, "br11");
    issue(1'b0, SZ_HALF, 32'h10, '0, 32'h0000AAEF, 1'b0, 0, "hr10");
    issue(1'b0, SZ_BYTE, 32'h10, '0, 32'h000000EF, 1'b0, 0, "br10");

    // Faults: rdata must stay at the last load result
    issue(1'b0, SZ_WORD, 32'h02, '0, '0, 1'b1, 0, "flt_misalign_word");
    issue(1'b1, SZ_HALF, 32'h05, 32'hFFFF, '0, 1'b1, 0, "flt_misalign_half");
    issue(1'b0, SZ_WORD, DEPTH * 4, '0, '0, 1'b1, 0, "flt_range");
`ifdef MEM_RESP_ERRCNT_EN
    check("err_count_3", {24'd0, err_count}, 32'd3);
`endif
    issue(1'b0, 2'b11, 32'h04, '0, '0, 1'b1, 0, "flt_reserved");
`ifdef MEM_RESP_ERRCNT_EN
    check("err_count_4", {24'd0, err_count}, 32'd4);
`endif
    issue(1'b0, SZ_WORD, 32'h04, '0, 32'h11223344, 1'b0, 0, "r04_unchanged");

    // Half store to upper lane; last word byte store
    issue(1'b1, SZ_HALF, 32'h06, 32'hFFFFBEEF, '0, 1'b0, 1, "hw06");
    issue(1'b0, SZ_WORD, 32'h04, '0, 32'hBEEF3344, 1'b0, 0, "r04_after_hw");
    issue(1'b1, SZ_BYTE, 32'h3FF, 32'h12345677, '0, 1'b0, 1, "bw3ff");
    issue(1'b0, SZ_WORD, 32'h3FC, '0, 32'h77020304, 1'b0, 0, "r3fc");

    // Request while busy is ignored
    n0 = n_ready;
    @(negedge Clk);
    drive(1'b0, SZ_WORD, 32'h10, '0);
    @(posedge Clk);
    #1;
    expect_resp(1'b0, 32'hDEADAAEF, 1'b0, 0, "busy_r10");
    bus.req = 1'b0;
    @(negedge Clk);
    drive(1'b1, SZ_WORD, 32'h10, 32'h0);
    @(posedge Clk);
    #1;
    bus.req = 1'b0;
    check("busy_during", {31'd0, bus.busy}, 32'd1);
    wait_done("busy_r10");
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    repeat (6) @(negedge Clk);
    check("busy_one_ready", n_ready - n0, 32'd1);
    issue(1'b0, SZ_WORD, 32'h10, '0, 32'hDEADAAEF, 1'b0, 0, "r10_after_ignored");

    // Reset during WAIT abandons the write
    @(negedge Clk);
    drive(1'b1, SZ_WORD, 32'h20, 32'h12345678);
    @(posedge Clk);
    #1;
    bus.req = 1'b0;
    check("abort_busy_wait", {31'd0, bus.busy}, 32'd1);
    @(negedge Clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_ready", {31'd0, bus.ready}, 32'd0);
    check("abort_rdata", bus.rdata, 32'd0);
`ifdef MEM_RESP_ERRCNT_EN
    check("abort_err_count", {24'd0, err_count}, 32'd0);
`endif
    last_rdata = '0;
    repeat (2) @(negedge Clk);
    reset = 1'b1;
    issue(1'b0, SZ_WORD, 32'h20, '0, 32'hCAFEF00D, 1'b0, 0, "r20_after_abort");

    repeat (3) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
